elevator_ctrl: RTL

//   Parametrised N-floor elevator controller for the FPGA elevator design.

---
 rtl/elevator_ctrl.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/elevator_ctrl.sv
// elevator_ctrl: N-floor elevator controller using a SCAN policy.
//   Active-low buttons are latched into a pending-request vector. The car keeps
//   moving in its current direction while requests lie ahead, otherwise it
//   settles in IDLE, which picks a new direction. Floor-to-floor travel and
//   door dwell are timed by a shared internal counter.
//
// Ports:
//   clk        in   1         system clock
//   rst        in   1         synchronous reset, active-high
//   req_n      in   N_FLOORS  floor request buttons, active-low, synchronous
//   moving     out  1         1 while the car travels between floors
//   dir_up     out  1         1 = up/last-up, 0 = down
//   cur_floor  out  FW        current floor index (FW = $clog2(N_FLOORS))
//   door_open  out  1         1 while doors are open at cur_floor
//   pending    out  N_FLOORS  registered outstanding requests
//
// Build option:
//   ELEV_DOOR_REOPEN_EN  when defined, pressing the current floor's button while
//                        the door is open restarts the door dwell.

module elevator_ctrl #(
  parameter int N_FLOORS      = 4,
  parameter int TRAVEL_CYCLES = 50000000,
  parameter int DOOR_CYCLES   = 100000000
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_FLOORS-1:0]         req_n,
  output logic                        moving,
  output logic                        dir_up,
  output logic [$clog2(N_FLOORS)-1:0] cur_floor,
  output logic                        door_open,
  output logic [N_FLOORS-1:0]         pending
);

  localparam int FW   = $clog2(N_FLOORS);
  localparam int MAXC = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
  localparam int TW   = $clog2(MAXC);

  localparam logic [TW-1:0] TRAVEL_LAST = TW'(TRAVEL_CYCLES - 1);
  localparam logic [TW-1:0] DOOR_LAST   = TW'(DOOR_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MOVE,
    S_DOOR
  } state_t;

  state_t              state;
  logic [TW-1:0]       timer;
  logic [FW-1:0]       nxt_floor;
  logic [N_FLOORS-1:0] set_mask;
  logic [N_FLOORS-1:0] clr_mask;
  logic [N_FLOORS-1:0] pend_lat;
  logic                travel_done;
  logic                door_done;
  logic                reopen;
  logic                up_any;
  logic                dn_any;
  logic                ahead_any;

  // Any pending request strictly above (up=1) or below (up=0) floor f.
  function automatic logic pending_beyond(input logic [N_FLOORS-1:0] p,
                                          input logic [FW-1:0]       f,
                                          input logic                up);
    logic hit;
    hit = 1'b0;
    for (int unsigned i = 0; i < N_FLOORS; i++) begin
      if (p[i] && (up ? (i > 32'(f)) : (i < 32'(f))))
        hit = 1'b1;
    end
    return hit;
  endfunction

  assign moving    = (state == S_MOVE);
  assign door_open = (state == S_DOOR);

  always_comb begin
    nxt_floor   = dir_up ? cur_floor + FW'(1) : cur_floor - FW'(1);
    travel_done = (timer == TRAVEL_LAST);
    door_done   = (timer == DOOR_LAST);

`ifdef ELEV_DOOR_REOPEN_EN
    reopen = (state == S_DOOR) && !req_n[cur_floor];
`else
    reopen = 1'b0;
`endif

    // The open floor's own button is never latched while the door is open.
    set_mask = ~req_n;
    if (state == S_DOOR)
      set_mask[cur_floor] = 1'b0;

    up_any    = pending_beyond(pending, cur_floor, 1'b1);
    dn_any    = pending_beyond(pending, cur_floor, 1'b0);
    ahead_any = pending_beyond(pending, nxt_floor, dir_up);

    // Serving a floor clears its bit; clear wins over a same-edge press.
    clr_mask = '0;
    if (state == S_IDLE && pending[cur_floor])
      clr_mask[cur_floor] = 1'b1;
    if (state == S_MOVE && travel_done && pending[nxt_floor])
      clr_mask[nxt_floor] = 1'b1;

    pend_lat = (pending | set_mask) & ~clr_mask;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cur_floor <= '0;
      dir_up    <= 1'b1;
      pending   <= '0;
      timer     <= '0;
    end else begin
      pending <= pend_lat;
      case (state)
        S_IDLE: begin
          timer <= '0;
          if (pending[cur_floor]) begin
            state <= S_DOOR;
          end else if (up_any && (dir_up || !dn_any)) begin
            dir_up <= 1'b1;
            state  <= S_MOVE;
          end else if (dn_any) begin
            dir_up <= 1'b0;
            state  <= S_MOVE;
          end
        end
        S_MOVE: begin
          if (travel_done) begin
            timer     <= '0;
            cur_floor <= nxt_floor;
            // Arrival decision uses the requests known before this edge.
            if (pending[nxt_floor])
              state <= S_DOOR;
            else if (!ahead_any)
              state <= S_IDLE;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        S_DOOR: begin
          if (reopen) begin
            timer <= '0;
          end else if (door_done) begin
            timer <= '0;
            state <= S_IDLE;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        default: begin
          state <= S_IDLE;
          timer <= '0;
        end
      endcase
    end
  end

endmodule
